// File: rtl/internal_node_cfg_ctrl.sv
// rtl/internal_node_cfg_ctrl.sv - loads {median,index} words into a kd-tree level and gates queries until configured
module internal_node_cfg_ctrl #(
    parameter int STORAGE_WIDTH = 22,
    parameter int NUM_NODES     = 31,
    parameter int CNT_WIDTH     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cfg_valid,
    input  logic [STORAGE_WIDTH-1:0] cfg_data,
    output logic                     cfg_ready,
    output logic [NUM_NODES-1:0]     node_wen,
    output logic [STORAGE_WIDTH-1:0] node_wdata,
    input  logic                     query_valid_in,
    input  logic                     query_valid_two_in,
    output logic                     query_valid_out,
    output logic                     query_valid_two_out,
    output logic [CNT_WIDTH-1:0]     load_count,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        READY = 2'd3
    } state_t;

    localparam logic [NUM_NODES-1:0] WEN_ONE   = NUM_NODES'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_NODE = CNT_WIDTH'(NUM_NODES - 1);

    state_t state_q;
    state_t state_d;
    logic   handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        // start takes priority over everything, so no beat is accepted in its cycle
        cfg_ready = (state_q == LOAD) && !start;
        handshake = cfg_ready && cfg_valid;
        case (state_q)
            IDLE:    state_d = IDLE;
            LOAD:    if (handshake && (load_count == LAST_NODE)) state_d = FLUSH;
            FLUSH:   state_d = READY;
            READY:   state_d = READY;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_wen   <= '0;
            node_wdata <= '0;
            load_count <= '0;
        end else begin
            node_wen <= '0;
            if (start) begin
                load_count <= '0;
            end else if (handshake) begin
                node_wdata <= cfg_data;
                node_wen   <= WEN_ONE << load_count;
                load_count <= load_count + CNT_WIDTH'(1);
            end
        end
    end

    assign busy                = (state_q == LOAD) || (state_q == FLUSH);
    assign done                = (state_q == READY);
    assign query_valid_out     = done && query_valid_in;
    assign query_valid_two_out = done && query_valid_two_in;

endmodule

// File: tb/tb_internal_node_cfg_ctrl.sv
// tb/tb_internal_node_cfg_ctrl.sv - self-checking bench for internal_node_cfg_ctrl
module tb_internal_node_cfg_ctrl;

    localparam int SW = 22;
    localparam int NN = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cfg_valid;
    logic [SW-1:0] cfg_data;
    logic          cfg_ready;
    logic [NN-1:0] node_wen;
    logic [SW-1:0] node_wdata;
    logic          query_valid_in;
    logic          query_valid_two_in;
    logic          query_valid_out;
    logic          query_valid_two_out;
    logic [CW-1:0] load_count;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    logic [SW-1:0] beats [3];

    internal_node_cfg_ctrl #(
        .STORAGE_WIDTH(SW),
        .NUM_NODES    (NN),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .cfg_valid          (cfg_valid),
        .cfg_data           (cfg_data),
        .cfg_ready          (cfg_ready),
        .node_wen           (node_wen),
        .node_wdata         (node_wdata),
        .query_valid_in     (query_valid_in),
        .query_valid_two_in (query_valid_two_in),
        .query_valid_out    (query_valid_out),
        .query_valid_two_out(query_valid_two_out),
        .load_count         (load_count),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; cfg_valid = 1'b1; cfg_data = 22'h3fffff;
        query_valid_in = 1'b1; query_valid_two_in = 1'b1;
        #1;
        tick(); tick();
        n_vec++;
        if ({cfg_ready, node_wen, node_wdata, load_count, busy, done, query_valid_out, query_valid_two_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b wen=%b wdata=%h cnt=%0d busy=%b done=%b qv=%b%b, required all 0",
                     cfg_ready, node_wen, node_wdata, load_count, busy, done, query_valid_out, query_valid_two_out);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0 || node_wen !== '0 || query_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b done=%b ready=%b wen=%b qv=%b, required idle zeros",
                     busy, done, cfg_ready, node_wen, query_valid_out);
        end
    endtask

    task automatic test_back_to_back();
        query_valid_in = 1'b1; query_valid_two_in = 1'b1;
        start = 1'b1; cfg_valid = 1'b0;
        #1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NN; i++) begin
            cfg_valid = 1'b1; cfg_data = beats[i];
            #1;
            n_vec++;
            if (cfg_ready !== 1'b1 || query_valid_out !== 1'b0 || query_valid_two_out !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: ready=%b qv=%b%b, required ready=1 qv=00",
                         i, cfg_ready, query_valid_out, query_valid_two_out);
            end
            if (i > 0) begin
                n_vec++;
                if (node_wen !== NN'(1 << (i - 1)) || node_wdata !== beats[i-1]) begin
                    n_err++;
                    $display("FAIL b2b_write[%0d]: wen=%b wdata=%h, required wen=%b wdata=%h",
                             i - 1, node_wen, node_wdata, NN'(1 << (i - 1)), beats[i-1]);
                end
            end
            tick();
        end
        cfg_valid = 1'b0;
        #1;
        n_vec++;
        if (node_wen !== 3'b100 || node_wdata !== beats[2] || busy !== 1'b1 || done !== 1'b0 ||
            cfg_ready !== 1'b0 || query_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_flush: wen=%b wdata=%h busy=%b done=%b ready=%b qv=%b, required 100/%h/1/0/0/0",
                     node_wen, node_wdata, busy, done, cfg_ready, query_valid_out, beats[2]);
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || node_wen !== '0 || load_count !== CW'(NN) ||
            query_valid_out !== 1'b1 || query_valid_two_out !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_state: done=%b busy=%b wen=%b cnt=%0d qv=%b%b, required 1/0/000/3/11",
                     done, busy, node_wen, load_count, query_valid_out, query_valid_two_out);
        end
        query_valid_in = 1'b0;
        #1;
        n_vec++;
        if (query_valid_out !== 1'b0 || query_valid_two_out !== 1'b1) begin
            n_err++;
            $display("FAIL query_gate_pass: qv=%b qv2=%b, required 0 1", query_valid_out, query_valid_two_out);
        end
        query_valid_in = 1'b1;
        cfg_valid = 1'b1;
        tick();
        n_vec++;
        if (cfg_ready !== 1'b0 || node_wen !== '0 || load_count !== CW'(NN)) begin
            n_err++;
            $display("FAIL ready_no_accept: ready=%b wen=%b cnt=%0d, required 0/000/3", cfg_ready, node_wen, load_count);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_stall();
        int hs;
        logic pattern [5];
        pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        hs = 0;
        start = 1'b1; cfg_valid = 1'b0;
        #1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cfg_valid = pattern[c];
            cfg_data  = pattern[c] ? beats[hs] : 22'h155555;
            #1;
            if (c > 0) begin
                n_vec++;
                if (pattern[c-1]) begin
                    if (node_wen !== NN'(1 << (hs - 1)) || node_wdata !== beats[hs-1]) begin
                        n_err++;
                        $display("FAIL stall_write[%0d]: wen=%b wdata=%h, required %b/%h",
                                 c, node_wen, node_wdata, NN'(1 << (hs - 1)), beats[hs-1]);
                    end
                end else if (node_wen !== '0 || node_wdata !== beats[hs-1]) begin
                    n_err++;
                    $display("FAIL stall_gap[%0d]: wen=%b wdata=%h, required 000/%h", c, node_wen, node_wdata, beats[hs-1]);
                end
            end
            if (pattern[c]) hs++;
            tick();
        end
        cfg_valid = 1'b0;
        #1;
        n_vec++;
        if (done !== 1'b0 || node_wen !== 3'b100) begin
            n_err++;
            $display("FAIL stall_flush: done=%b wen=%b, required 0/100", done, node_wen);
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || load_count !== CW'(NN)) begin
            n_err++;
            $display("FAIL stall_done: done=%b cnt=%0d, required 1/3", done, load_count);
        end
    endtask

    task automatic test_restart();
        start = 1'b1; cfg_valid = 1'b0;
        #1;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL restart_pre: done=%b, required 1", done);
        end
        tick();
        start = 1'b0; cfg_valid = 1'b1; cfg_data = 22'h0abcde;
        #1;
        tick();
        start = 1'b1; cfg_data = 22'h3c3c3c;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b0 || node_wen !== 3'b001 || node_wdata !== 22'h0abcde) begin
            n_err++;
            $display("FAIL restart_block: ready=%b wen=%b wdata=%h, required 0/001/0abcde", cfg_ready, node_wen, node_wdata);
        end
        tick();
        start = 1'b0; cfg_valid = 1'b0;
        #1;
        n_vec++;
        if (load_count !== '0 || node_wen !== '0 || node_wdata !== 22'h0abcde || busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL restart_clear: cnt=%0d wen=%b wdata=%h busy=%b done=%b, required 0/000/0abcde/1/0",
                     load_count, node_wen, node_wdata, busy, done);
        end
        for (int i = 0; i < NN; i++) begin
            cfg_valid = 1'b1; cfg_data = beats[NN-1-i];
            #1;
            tick();
            n_vec++;
            if (node_wen !== NN'(1 << i) || node_wdata !== beats[NN-1-i]) begin
                n_err++;
                $display("FAIL restart_write[%0d]: wen=%b wdata=%h, required %b/%h",
                         i, node_wen, node_wdata, NN'(1 << i), beats[NN-1-i]);
            end
        end
        cfg_valid = 1'b0;
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL restart_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_reset_mid_load();
        query_valid_in = 1'b1; query_valid_two_in = 1'b1;
        start = 1'b1; cfg_valid = 1'b0;
        #1;
        tick();
        start = 1'b0; cfg_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cfg_data = beats[i];
            #1;
            tick();
        end
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (node_wen !== '0 || load_count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: wen=%b cnt=%0d busy=%b done=%b, required 000/0/0/0", node_wen, load_count, busy, done);
        end
        tick();
        rst_n = 1'b1;
        cfg_valid = 1'b1;
        tick(); tick();
        n_vec++;
        if (done !== 1'b0 || query_valid_out !== 1'b0 || query_valid_two_out !== 1'b0 || cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_block: done=%b qv=%b%b ready=%b, required 0/00/0",
                     done, query_valid_out, query_valid_two_out, cfg_ready);
        end
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NN; i++) begin
            cfg_data = beats[i];
            #1;
            tick();
        end
        cfg_valid = 1'b0;
        tick();
        n_vec++;
        if (done !== 1'b1 || query_valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL reload_done: done=%b qv=%b, required 1/1", done, query_valid_out);
        end
    endtask

    // Reference: tracks whether a load is in progress, how many beats landed, and which node was last written.
    task automatic test_random();
        bit            m_loading, m_flush, m_done;
        int            m_count, m_wen_idx;
        logic [SW-1:0] m_wdata;
        logic [NN-1:0] exp_wen;
        bit            exp_ready;
        rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        m_loading = 0; m_flush = 0; m_done = 0; m_count = 0; m_wen_idx = -1; m_wdata = '0;
        for (int c = 0; c < 600; c++) begin
            start              = ($urandom_range(0, 24) == 0);
            cfg_valid          = $urandom_range(0, 2) != 0;
            cfg_data           = SW'($urandom);
            query_valid_in     = $urandom_range(0, 1) != 0;
            query_valid_two_in = $urandom_range(0, 1) != 0;
            #1;
            exp_ready = m_loading && !start;
            exp_wen   = (m_wen_idx >= 0) ? NN'(1 << m_wen_idx) : '0;
            n_vec++;
            if (cfg_ready !== exp_ready || node_wen !== exp_wen || node_wdata !== m_wdata ||
                load_count !== CW'(m_count) || busy !== (m_loading || m_flush) || done !== m_done ||
                query_valid_out !== (m_done && query_valid_in) ||
                query_valid_two_out !== (m_done && query_valid_two_in)) begin
                n_err++;
                $display("FAIL random[%0d]: ready=%b wen=%b wdata=%h cnt=%0d busy=%b done=%b qv=%b%b, required %b/%b/%h/%0d/%b/%b/%b%b",
                         c, cfg_ready, node_wen, node_wdata, load_count, busy, done,
                         query_valid_out, query_valid_two_out, exp_ready, exp_wen, m_wdata, m_count,
                         m_loading || m_flush, m_done, m_done && query_valid_in, m_done && query_valid_two_in);
            end
            if (start) begin
                m_loading = 1; m_flush = 0; m_done = 0; m_count = 0; m_wen_idx = -1;
            end else if (exp_ready && cfg_valid) begin
                m_wen_idx = m_count;
                m_wdata   = cfg_data;
                m_count++;
                if (m_count == NN) begin
                    m_loading = 0;
                    m_flush   = 1;
                end
            end else begin
                m_wen_idx = -1;
                if (m_flush) begin
                    m_flush = 0;
                    m_done  = 1;
                end
            end
            tick();
        end
        start = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        beats[0] = 22'h001001;
        beats[1] = 22'h002004;
        beats[2] = 22'h003002;
        #2;
        test_reset();
        test_back_to_back();
        test_stall();
        test_restart();
        test_reset_mid_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
